id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Parameters
REQ-001 The block SHALL have parameter NB_ADDR, default 5, meaning register-file address width.
REQ-002 The block SHALL have parameter NB_DATA, default 32, meaning datapath width.
REQ-003 The block SHALL have parameter NB_CTRL, default 11, meaning control bundle width.
REQ-004 The block SHALL have parameter NB_CNT, default 16, meaning bubble counter width.

Interface
REQ-005 The block SHALL provide i_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL provide i_reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL provide i_enable, input, 1 bit: pipeline advance; when 0, all state holds.
REQ-008 The block SHALL provide i_flush, input, 1 bit: branch-taken kill of the decode-stage instruction.
REQ-009 The block SHALL provide i_valid, input, 1 bit: the decode-stage instruction is valid.
REQ-010 The block SHALL provide i_ctrl, input, NB_CTRL bits: decode control bundle; bit order is [10] rf_wr_data_src, [9] rf_wr_addr_src, [8] rf_wr_enb, [7] branch, [6] data_mem_rd_enb, [5] data_mem_wr_enb, [4] alu_data_src, [3:2] alu_operation, [1] signed_operation, [0] inmediate_operation.
REQ-011 The block SHALL provide i_rs_addr, i_rt_addr and i_rd_addr, inputs, NB_ADDR bits each: decoded register fields.
REQ-012 The block SHALL provide i_rs_data and i_rt_data, inputs, NB_DATA bits each: register-file read data.
REQ-013 The block SHALL provide i_imm and i_pc, inputs, NB_DATA bits each: sign-extended immediate and PC+4.
REQ-014 The block SHALL provide o_ctrl, output, NB_CTRL bits: registered control bundle, same bit order as i_ctrl.
REQ-015 The block SHALL provide o_rs_data, o_rt_data, o_imm and o_pc, outputs, NB_DATA bits each: registered copies of the corresponding inputs.
REQ-016 The block SHALL provide o_rs_addr, o_rt_addr and o_wr_addr, outputs, NB_ADDR bits each: registered addresses; o_wr_addr is the resolved destination register.
REQ-017 The block SHALL provide o_valid, output, 1 bit: the execute-stage instruction is valid.
REQ-018 The block SHALL provide o_stall, output, 1 bit, combinational: hold request to the PC and the IF/ID register.
REQ-019 The block SHALL provide o_bubble_count, output, NB_CNT bits: count of bubbles inserted.

Function
REQ-020 The block SHALL drive o_stall = o_valid & o_ctrl[6] & o_ctrl[8] & (o_wr_addr != 0) & i_valid & ((o_wr_addr == i_rs_addr) | (o_wr_addr == i_rt_addr)) (load-use hazard).
REQ-021 The block SHALL set the resolved write address to i_rd_addr when i_ctrl[9] = 1, else to i_rt_addr; it is registered into o_wr_addr.
REQ-022 Per rising edge, the block SHALL apply the first matching rule in priority order: i_reset, then i_enable = 0 (hold), then i_flush or o_stall (insert bubble), then load.
REQ-023 Load SHALL register all inputs, with o_valid <= i_valid; if i_valid = 0, o_ctrl SHALL be loaded as all zeros.
REQ-024 Bubble SHALL set o_ctrl to 0 and o_valid to 0; data and address registers may load or hold (don't care).
REQ-025 Bubble SHALL increment o_bubble_count, saturating at 2^NB_CNT-1 with no wrap.
REQ-026 When i_flush and o_stall are both true, the block SHALL insert exactly one bubble and increment the counter by 1.
REQ-027 Hold SHALL leave all registers and the counter unchanged; o_stall stays combinationally valid during hold.
REQ-028 The block SHALL have a latency of 1 cycle from input to output.
REQ-029 A stall SHALL last exactly one cycle per load-use hazard, because the bubble clears o_valid.

Reset
REQ-030 On i_reset = 1 at a clock edge, all outputs SHALL go to 0, including o_bubble_count; o_stall is therefore 0.
REQ-031 Reset asserted mid-stall SHALL discard the stalled state; no bubble is counted on that edge.

Verification
REQ-032 Scenario: reset, then i_enable = 1, i_valid = 1, i_ctrl = 11'b011_0000_0000 (R-type), rd = 3, rt = 2 -> next cycle o_wr_addr = 3, o_valid = 1, o_ctrl = the input value.
REQ-033 Scenario: load (i_ctrl[10,8,6,4] = 1, rt = 5, i_ctrl[9] = 0), followed by an instruction with rs = 5 -> o_stall = 1 for one cycle; then o_valid = 0, o_ctrl = 0, o_bubble_count = 1; the consumer enters the following cycle with o_stall = 0.
REQ-034 Scenario: load with rt = 0, followed by an instruction with rs = 0 -> o_stall = 0 and no bubble.
REQ-035 Scenario: i_flush = 1 together with a load-use hazard -> one bubble, o_bubble_count increments by exactly 1.
REQ-036 Scenario: i_enable = 0 for 3 cycles with a pending hazard -> outputs and counter frozen, o_stall held at 1; when i_enable returns to 1 the bubble is inserted.
REQ-037 Scenario: preload the counter to 2^16-1 via repeated bubbles, then one more bubble -> o_bubble_count stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Latency: 1 cycle; i_enable=0 freezes all state, and o_stall asks the upstream stages to hold.
module id_ex_stage #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32,
    parameter int NB_CTRL = 11,
    parameter int NB_CNT  = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_ADDR-1:0] i_rs_addr,
    input  logic [NB_ADDR-1:0] i_rt_addr,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic [NB_DATA-1:0] i_imm,
    input  logic [NB_DATA-1:0] i_pc,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    output logic [NB_DATA-1:0] o_imm,
    output logic [NB_DATA-1:0] o_pc,
    output logic [NB_ADDR-1:0] o_rs_addr,
    output logic [NB_ADDR-1:0] o_rt_addr,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic               o_valid,
    output logic               o_stall,
    output logic [NB_CNT-1:0]  o_bubble_count
);

    localparam int CTRL_WR_ADDR_SRC = 9;
    localparam int CTRL_RF_WR_ENB   = 8;
    localparam int CTRL_MEM_RD_ENB  = 6;

    logic [NB_ADDR-1:0] wr_addr_next;
    logic               ex_is_load;
    logic               addr_match;
    logic               bubble;

    assign wr_addr_next = i_ctrl[CTRL_WR_ADDR_SRC] ? i_rd_addr : i_rt_addr;

    // A load in EX whose destination feeds the decode-stage instruction needs one bubble.
    // r0 is hardwired to zero, so it never creates a dependency.
    assign ex_is_load = o_valid & o_ctrl[CTRL_MEM_RD_ENB] & o_ctrl[CTRL_RF_WR_ENB]
                      & (o_wr_addr != '0);
    assign addr_match = (o_wr_addr == i_rs_addr) | (o_wr_addr == i_rt_addr);
    assign o_stall    = ex_is_load & i_valid & addr_match;
    assign bubble     = i_flush | o_stall;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_ctrl         <= '0;
            o_rs_data      <= '0;
            o_rt_data      <= '0;
            o_imm          <= '0;
            o_pc           <= '0;
            o_rs_addr      <= '0;
            o_rt_addr      <= '0;
            o_wr_addr      <= '0;
            o_valid        <= 1'b0;
            o_bubble_count <= '0;
        end else if (i_enable) begin
            if (bubble) begin
                // Data and address registers hold; only control and valid are killed.
                o_ctrl  <= '0;
                o_valid <= 1'b0;
                if (o_bubble_count != {NB_CNT{1'b1}})
                    o_bubble_count <= o_bubble_count + NB_CNT'(1);
            end else begin
                o_ctrl    <= i_valid ? i_ctrl : '0;
                o_rs_data <= i_rs_data;
                o_rt_data <= i_rt_data;
                o_imm     <= i_imm;
                o_pc      <= i_pc;
                o_rs_addr <= i_rs_addr;
                o_rt_addr <= i_rt_addr;
                o_wr_addr <= wr_addr_next;
                o_valid   <= i_valid;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load, load-use stall, flush, hold, reset and counter saturation.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        flush;
    logic        valid;
    logic [10:0] ctrl;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] rs_data, rt_data, imm, pc;
    logic [10:0] q_ctrl;
    logic [31:0] q_rs_data, q_rt_data, q_imm, q_pc;
    logic [4:0]  q_rs_addr, q_rt_addr, q_wr_addr;
    logic        q_valid;
    logic        stall;
    logic [15:0] bubble_count;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [10:0] CTRL_RTYPE = 11'b011_0000_0000;
    localparam logic [10:0] CTRL_LOAD  = 11'b101_0101_0000;

    id_ex_stage dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_enable       (enable),
        .i_flush        (flush),
        .i_valid        (valid),
        .i_ctrl         (ctrl),
        .i_rs_addr      (rs_addr),
        .i_rt_addr      (rt_addr),
        .i_rd_addr      (rd_addr),
        .i_rs_data      (rs_data),
        .i_rt_data      (rt_data),
        .i_imm          (imm),
        .i_pc           (pc),
        .o_ctrl         (q_ctrl),
        .o_rs_data      (q_rs_data),
        .o_rt_data      (q_rt_data),
        .o_imm          (q_imm),
        .o_pc           (q_pc),
        .o_rs_addr      (q_rs_addr),
        .o_rt_addr      (q_rt_addr),
        .o_wr_addr      (q_wr_addr),
        .o_valid        (q_valid),
        .o_stall        (stall),
        .o_bubble_count (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [10:0] c, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd);
        valid   = 1'b1;
        ctrl    = c;
        rs_addr = rs;
        rt_addr = rt;
        rd_addr = rd;
        #1;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0; valid = 1'b0; ctrl = '0;
        rs_addr = '0; rt_addr = '0; rd_addr = '0;
        rs_data = 32'h1111_1111; rt_data = 32'h2222_2222; imm = 32'h44; pc = 32'h104;
        step();
        step();
        check("rst_ctrl",  32'(q_ctrl), 32'h0);
        check("rst_valid", 32'(q_valid), 32'h0);
        check("rst_wr",    32'(q_wr_addr), 32'h0);
        check("rst_cnt",   32'(bubble_count), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_pc",    q_pc, 32'h0);

        // R-type: destination comes from rd
        rst = 1'b0; enable = 1'b1;
        set_instr(CTRL_RTYPE, 5'd1, 5'd2, 5'd3);
        step();
        check("rt_wr",    32'(q_wr_addr), 32'd3);
        check("rt_valid", 32'(q_valid), 32'h1);
        check("rt_ctrl",  32'(q_ctrl), 32'(CTRL_RTYPE));
        check("rt_rsd",   q_rs_data, 32'h1111_1111);
        check("rt_pc",    q_pc, 32'h104);
        check("rt_imm",   q_imm, 32'h44);

        // Load to r5 then consumer reading r5 through rs
        set_instr(CTRL_LOAD, 5'd1, 5'd5, 5'd7);
        step();
        check("ld_wr",   32'(q_wr_addr), 32'd5);
        check("ld_ctrl", 32'(q_ctrl), 32'(CTRL_LOAD));
        set_instr(CTRL_RTYPE, 5'd5, 5'd6, 5'd8);
        check("lu_stall", 32'(stall), 32'h1);
        step();
        check("lu_bub_valid", 32'(q_valid), 32'h0);
        check("lu_bub_ctrl",  32'(q_ctrl), 32'h0);
        check("lu_bub_cnt",   32'(bubble_count), 32'd1);
        check("lu_bub_stall", 32'(stall), 32'h0);
        step();
        check("lu_cons_valid", 32'(q_valid), 32'h1);
        check("lu_cons_wr",    32'(q_wr_addr), 32'd8);
        check("lu_cons_rs",    32'(q_rs_addr), 32'd5);
        check("lu_cons_cnt",   32'(bubble_count), 32'd1);

        // Load to r0 never stalls
        set_instr(CTRL_LOAD, 5'd1, 5'd0, 5'd7);
        step();
        check("r0_wr", 32'(q_wr_addr), 32'd0);
        set_instr(CTRL_RTYPE, 5'd0, 5'd0, 5'd9);
        check("r0_stall", 32'(stall), 32'h0);
        step();
        check("r0_valid", 32'(q_valid), 32'h1);
        check("r0_wr2",   32'(q_wr_addr), 32'd9);
        check("r0_cnt",   32'(bubble_count), 32'd1);

        // Flush coinciding with a load-use hazard counts one bubble
        set_instr(CTRL_LOAD, 5'd1, 5'd5, 5'd7);
        step();
        set_instr(CTRL_RTYPE, 5'd5, 5'd6, 5'd8);
        flush = 1'b1;
        #1;
        check("fl_stall", 32'(stall), 32'h1);
        step();
        check("fl_cnt",   32'(bubble_count), 32'd2);
        check("fl_valid", 32'(q_valid), 32'h0);
        flush = 1'b0;
        step();
        check("fl_next_valid", 32'(q_valid), 32'h1);
        check("fl_next_cnt",   32'(bubble_count), 32'd2);

        // Hold with a pending hazard (rt match) for three cycles
        set_instr(CTRL_LOAD, 5'd1, 5'd5, 5'd7);
        step();
        set_instr(CTRL_RTYPE, 5'd2, 5'd5, 5'd8);
        enable = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_stall", 32'(stall), 32'h1);
            check("hold_ctrl",  32'(q_ctrl), 32'(CTRL_LOAD));
            check("hold_valid", 32'(q_valid), 32'h1);
            check("hold_cnt",   32'(bubble_count), 32'd2);
        end
        enable = 1'b1;
        step();
        check("hold_bub_cnt",   32'(bubble_count), 32'd3);
        check("hold_bub_valid", 32'(q_valid), 32'h0);

        // Invalid instruction loads zero control
        valid = 1'b0; ctrl = CTRL_LOAD;
        step();
        check("inv_ctrl",  32'(q_ctrl), 32'h0);
        check("inv_valid", 32'(q_valid), 32'h0);
        check("inv_cnt",   32'(bubble_count), 32'd3);

        // Reset mid-stall discards the stall and clears the counter
        set_instr(CTRL_LOAD, 5'd1, 5'd5, 5'd7);
        step();
        set_instr(CTRL_RTYPE, 5'd5, 5'd6, 5'd8);
        check("rs_pre_stall", 32'(stall), 32'h1);
        rst = 1'b1;
        step();
        check("rs_cnt",   32'(bubble_count), 32'd0);
        check("rs_valid", 32'(q_valid), 32'h0);
        check("rs_stall", 32'(stall), 32'h0);
        check("rs_wr",    32'(q_wr_addr), 32'd0);

        // Saturation via repeated flush bubbles
        rst = 1'b0; valid = 1'b0; flush = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", 32'(bubble_count), 32'hFFFE);
        step();
        check("sat_ffff", 32'(bubble_count), 32'hFFFF);
        step();
        check("sat_hold", 32'(bubble_count), 32'hFFFF);
        flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
